// File: rtl/mem_data_ctrl_pkg.sv
// Shared types and encodings for the data-side memory controller.
// Access codes, state encoding and the latched request bundle.
package mem_data_ctrl_pkg;

  localparam int ROB_SIZE_WIDTH = 5;

  localparam logic [1:0] IO_ADDR_HI = 2'b11;

  localparam logic [1:0] STORE_B = 2'b00;
  localparam logic [1:0] STORE_H = 2'b01;
  localparam logic [1:0] STORE_W = 2'b10;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'b00,
    MEM_STORE = 2'b01,
    MEM_LOAD  = 2'b10
  } mem_state_e;

  typedef struct packed {
    logic [31:0]               addr;
    logic [31:0]               data;
    logic [2:0]                ltype;
    logic [2:0]                len;
    logic [ROB_SIZE_WIDTH-1:0] rob_id;
  } mem_req_t;

  // Low two bits of both store and load codes encode the size.
  function automatic logic [2:0] access_bytes(logic [1:0] sz);
    logic [2:0] n;
    unique case (sz)
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_data_ctrl_if.sv
// Request/response and byte-bus bundle of the data memory controller.
// slave: the controller; master: RoB/LSB plus the RAM/IO port.
interface mem_data_ctrl_if;
  import mem_data_ctrl_pkg::*;

  logic                      flush_in;
  logic                      rob_store_ready;
  logic [1:0]                rob_store_type;
  logic [31:0]               rob_store_addr;
  logic [31:0]               rob_store_value;
  logic                      mem_busy;
  logic                      lsb_load_valid;
  logic [2:0]                lsb_load_type;
  logic [31:0]               lsb_load_addr;
  logic [ROB_SIZE_WIDTH-1:0] lsb_load_rob_id;
  logic                      lsb_load_grant;
  logic                      mem_valid;
  logic [ROB_SIZE_WIDTH-1:0] mem_dependency;
  logic [31:0]               mem_value;
  logic [7:0]                mem_din;
  logic [7:0]                mem_dout;
  logic [31:0]               mem_a;
  logic                      mem_wr;
  logic                      io_buffer_full;

  modport slave (
    input  flush_in,
    input  rob_store_ready,
    input  rob_store_type,
    input  rob_store_addr,
    input  rob_store_value,
    input  lsb_load_valid,
    input  lsb_load_type,
    input  lsb_load_addr,
    input  lsb_load_rob_id,
    input  mem_din,
    input  io_buffer_full,
    output mem_busy,
    output lsb_load_grant,
    output mem_valid,
    output mem_dependency,
    output mem_value,
    output mem_dout,
    output mem_a,
    output mem_wr
  );

  modport master (
    output flush_in,
    output rob_store_ready,
    output rob_store_type,
    output rob_store_addr,
    output rob_store_value,
    output lsb_load_valid,
    output lsb_load_type,
    output lsb_load_addr,
    output lsb_load_rob_id,
    output mem_din,
    output io_buffer_full,
    input  mem_busy,
    input  lsb_load_grant,
    input  mem_valid,
    input  mem_dependency,
    input  mem_value,
    input  mem_dout,
    input  mem_a,
    input  mem_wr
  );

endinterface

// File: rtl/mem_data_ctrl_load_extend.sv
// Sign/zero extension of an assembled little-endian load word.
// Purely combinational.
module mem_data_ctrl_load_extend
  import mem_data_ctrl_pkg::*;
(
  input  logic [2:0]  type_i,
  input  logic [31:0] raw_i,
  output logic [31:0] value_o
);

  always_comb begin
    value_o = raw_i;
    unique case (1'b1)
      (type_i == LOAD_LB):
        value_o = {{24{raw_i[7]}}, raw_i[7:0]};
      (type_i == LOAD_LH):
        value_o = {{16{raw_i[15]}}, raw_i[15:0]};
      (type_i == LOAD_LBU):
        value_o = {24'h0, raw_i[7:0]};
      (type_i == LOAD_LHU):
        value_o = {16'h0, raw_i[15:0]};
      default:
        value_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_data_ctrl.sv
// Data-side memory controller: serializes RoB stores and LSB loads
// onto the byte-wide RAM/IO bus and returns extended load results.
module mem_data_ctrl
  import mem_data_ctrl_pkg::*;
(
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  mem_data_ctrl_if.slave  bus
);

  mem_state_e state_q, state_d;
  mem_req_t   req_q, req_d;

  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  rcnt_q, rcnt_d;
  logic        rd_q, rd_d;
  logic        din_ok_q;
  logic [31:0] buf_q, buf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        grant_q, grant_d;
  logic        valid_q, valid_d;
  logic [31:0] value_q, value_d;

  logic [ROB_SIZE_WIDTH-1:0] dep_q, dep_d;

  logic [31:0] merged;
  logic [31:0] ext_value;
  logic        io_stall;

  // mem_din always answers the address driven one cycle earlier.
  always_comb begin
    merged = buf_q;
    merged[{rcnt_q, 3'b000} +: 8] = bus.mem_din;
  end

  mem_data_ctrl_load_extend u_ext (
    .type_i  (req_q.ltype),
    .raw_i   (merged),
    .value_o (ext_value)
  );

  assign io_stall = (req_q.addr[17:16] == IO_ADDR_HI)
                  && bus.io_buffer_full;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    cnt_d      = cnt_q;
    rcnt_d     = rcnt_q;
    rd_d       = 1'b0;
    buf_d      = buf_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = 1'b0;
    grant_d    = 1'b0;
    valid_d    = 1'b0;
    dep_d      = dep_q;
    value_d    = value_q;
    unique case (state_q)
      MEM_IDLE: begin
        if (bus.rob_store_ready) begin
          req_d = '{
            addr:   bus.rob_store_addr,
            data:   bus.rob_store_value,
            ltype:  3'b000,
            len:    access_bytes(bus.rob_store_type),
            rob_id: '0
          };
          cnt_d   = 3'd0;
          state_d = MEM_STORE;
        end else if (bus.lsb_load_valid && !bus.flush_in) begin
          req_d = '{
            addr:   bus.lsb_load_addr,
            data:   32'h0,
            ltype:  bus.lsb_load_type,
            len:    access_bytes(bus.lsb_load_type[1:0]),
            rob_id: bus.lsb_load_rob_id
          };
          // First byte address goes out with the grant.
          mem_a_d = bus.lsb_load_addr;
          cnt_d   = 3'd1;
          rcnt_d  = 2'd0;
          rd_d    = 1'b1;
          grant_d = 1'b1;
          state_d = MEM_LOAD;
        end
      end
      MEM_STORE: begin
        if (!io_stall) begin
          mem_a_d    = req_q.addr + 32'(cnt_q);
          mem_dout_d = req_q.data[{cnt_q[1:0], 3'b000} +: 8];
          mem_wr_d   = 1'b1;
          cnt_d      = cnt_q + 3'd1;
          if (cnt_q == req_q.len - 3'd1) begin
            state_d = MEM_IDLE;
          end
        end
      end
      MEM_LOAD: begin
        if (bus.flush_in) begin
          state_d = MEM_IDLE;
        end else begin
          if (cnt_q < req_q.len) begin
            mem_a_d = req_q.addr + 32'(cnt_q);
            cnt_d   = cnt_q + 3'd1;
            rd_d    = 1'b1;
          end
          if (din_ok_q) begin
            buf_d  = merged;
            rcnt_d = rcnt_q + 2'd1;
            if ({1'b0, rcnt_q} == req_q.len - 3'd1) begin
              valid_d = 1'b1;
              dep_d   = req_q.rob_id;
              value_d = ext_value;
              state_d = MEM_IDLE;
            end
          end
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= MEM_IDLE;
      req_q      <= '0;
      cnt_q      <= 3'd0;
      rcnt_q     <= 2'd0;
      rd_q       <= 1'b0;
      din_ok_q   <= 1'b0;
      buf_q      <= 32'h0;
      mem_a_q    <= 32'h0;
      mem_dout_q <= 8'h0;
      mem_wr_q   <= 1'b0;
      grant_q    <= 1'b0;
      valid_q    <= 1'b0;
      dep_q      <= '0;
      value_q    <= 32'h0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      rcnt_q     <= rcnt_d;
      rd_q       <= rd_d;
      din_ok_q   <= rd_q;
      buf_q      <= buf_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      grant_q    <= grant_d;
      valid_q    <= valid_d;
      dep_q      <= dep_d;
      value_q    <= value_d;
    end
  end

  assign bus.mem_busy       = (state_q != MEM_IDLE)
                            || bus.rob_store_ready;
  assign bus.lsb_load_grant = grant_q;
  assign bus.mem_valid      = valid_q;
  assign bus.mem_dependency = dep_q;
  assign bus.mem_value      = value_q;
  assign bus.mem_a          = mem_a_q;
  assign bus.mem_dout       = mem_dout_q;
  assign bus.mem_wr         = mem_wr_q & rdy_in;

endmodule

// File: tb/tb_mem_data_ctrl.sv
// Directed bench for mem_data_ctrl: loads, stores, IO stall,
// freeze, flush, store/load arbitration and mid-load reset.
module tb_mem_data_ctrl;
  import mem_data_ctrl_pkg::*;

  logic clk;
  logic rst;
  logic rdy;
  int   errs;
  int   checks;

  logic [7:0] ram [0:1023];
  logic [7:0] sw_b [4];

  mem_data_ctrl_if bus ();

  mem_data_ctrl dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM: byte for last cycle's address.
  always @(posedge clk) begin
    bus.mem_din <= ram[bus.mem_a[9:0]];
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_load(string tag, logic [2:0] t,
                         logic [31:0] a, logic [4:0] id,
                         int lat, logic [31:0] ev);
    bus.lsb_load_valid  = 1'b1;
    bus.lsb_load_type   = t;
    bus.lsb_load_addr   = a;
    bus.lsb_load_rob_id = id;
    nxt();
    chk({tag, "_grant"}, 32'(bus.lsb_load_grant), 32'd1);
    bus.lsb_load_valid = 1'b0;
    for (int i = 2; i < lat; i++) nxt();
    chk({tag, "_early"}, 32'(bus.mem_valid), 32'd0);
    nxt();
    chk({tag, "_valid"}, 32'(bus.mem_valid), 32'd1);
    chk({tag, "_value"}, bus.mem_value, ev);
    chk({tag, "_dep"}, 32'(bus.mem_dependency), 32'(id));
    nxt();
    chk({tag, "_pulse"}, 32'(bus.mem_valid), 32'd0);
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    sw_b   = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h11;
    ram[10'h101] = 8'h22;
    ram[10'h102] = 8'h33;
    ram[10'h103] = 8'h44;
    ram[10'h200] = 8'h80;
    ram[10'h202] = 8'h01;
    ram[10'h203] = 8'h80;

    rst = 1'b1;
    rdy = 1'b1;
    bus.flush_in        = 1'b0;
    bus.rob_store_ready = 1'b0;
    bus.rob_store_type  = 2'b00;
    bus.rob_store_addr  = 32'h0;
    bus.rob_store_value = 32'h0;
    bus.lsb_load_valid  = 1'b0;
    bus.lsb_load_type   = 3'b000;
    bus.lsb_load_addr   = 32'h0;
    bus.lsb_load_rob_id = '0;
    bus.io_buffer_full  = 1'b0;

    // Reset state
    nxt();
    nxt();
    chk("rst_wr", 32'(bus.mem_wr), 32'd0);
    chk("rst_a", bus.mem_a, 32'h0);
    chk("rst_valid", 32'(bus.mem_valid), 32'd0);
    chk("rst_grant", 32'(bus.lsb_load_grant), 32'd0);
    chk("rst_busy", 32'(bus.mem_busy), 32'd0);
    rst = 1'b0;
    nxt();

    // LW 0x100, rob 7: address walk and result on cycle 6
    bus.lsb_load_valid  = 1'b1;
    bus.lsb_load_type   = LOAD_LW;
    bus.lsb_load_addr   = 32'h100;
    bus.lsb_load_rob_id = 5'd7;
    nxt();
    chk("lw_grant", 32'(bus.lsb_load_grant), 32'd1);
    chk("lw_busy", 32'(bus.mem_busy), 32'd1);
    bus.lsb_load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("lw_addr", bus.mem_a, 32'h100 + 32'(i));
      nxt();
    end
    chk("lw_early", 32'(bus.mem_valid), 32'd0);
    nxt();
    chk("lw_valid", 32'(bus.mem_valid), 32'd1);
    chk("lw_value", bus.mem_value, 32'h44332211);
    chk("lw_dep", 32'(bus.mem_dependency), 32'd7);
    nxt();
    chk("lw_pulse", 32'(bus.mem_valid), 32'd0);
    chk("lw_idle", 32'(bus.mem_busy), 32'd0);

    // Narrow loads with extension
    do_load("lb", LOAD_LB, 32'h200, 5'd3, 3, 32'hFFFFFF80);
    do_load("lbu", LOAD_LBU, 32'h200, 5'd4, 3, 32'h00000080);
    do_load("lh", LOAD_LH, 32'h202, 5'd5, 4, 32'hFFFF8001);
    do_load("lhu", LOAD_LHU, 32'h202, 5'd6, 4, 32'h00008001);

    // SW 0x300 = 0xDEADBEEF
    chk("sw_pre_busy", 32'(bus.mem_busy), 32'd0);
    bus.rob_store_ready = 1'b1;
    bus.rob_store_type  = STORE_W;
    bus.rob_store_addr  = 32'h300;
    bus.rob_store_value = 32'hDEADBEEF;
    #1;
    chk("sw_req_busy", 32'(bus.mem_busy), 32'd1);
    nxt();
    bus.rob_store_ready = 1'b0;
    chk("sw_c1_busy", 32'(bus.mem_busy), 32'd1);
    chk("sw_c1_wr", 32'(bus.mem_wr), 32'd0);
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk("sw_wr", 32'(bus.mem_wr), 32'd1);
      chk("sw_addr", bus.mem_a, 32'h300 + 32'(i));
      chk("sw_dout", 32'(bus.mem_dout), 32'(sw_b[i]));
      chk("sw_busy", 32'(bus.mem_busy), (i < 3) ? 32'd1 : 32'd0);
    end
    nxt();
    chk("sw_end_wr", 32'(bus.mem_wr), 32'd0);

    // SB to IO region with UART full for three cycles
    bus.rob_store_ready = 1'b1;
    bus.rob_store_type  = STORE_B;
    bus.rob_store_addr  = 32'h00030000;
    bus.rob_store_value = 32'h00000041;
    nxt();
    bus.rob_store_ready = 1'b0;
    bus.io_buffer_full  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) bus.io_buffer_full = 1'b0;
      #1;
      chk("io_stall_wr", 32'(bus.mem_wr), 32'd0);
      chk("io_stall_busy", 32'(bus.mem_busy), 32'd1);
      nxt();
    end
    chk("io_wr", 32'(bus.mem_wr), 32'd1);
    chk("io_addr", bus.mem_a, 32'h00030000);
    chk("io_dout", 32'(bus.mem_dout), 32'h41);
    nxt();
    chk("io_end_wr", 32'(bus.mem_wr), 32'd0);

    // rdy_in low gates mem_wr and freezes state
    bus.rob_store_ready = 1'b1;
    bus.rob_store_type  = STORE_B;
    bus.rob_store_addr  = 32'h310;
    bus.rob_store_value = 32'h0000005A;
    nxt();
    bus.rob_store_ready = 1'b0;
    nxt();
    rdy = 1'b0;
    #1;
    chk("rdy_gate_wr", 32'(bus.mem_wr), 32'd0);
    nxt();
    rdy = 1'b1;
    #1;
    chk("rdy_hold_wr", 32'(bus.mem_wr), 32'd1);
    chk("rdy_hold_dout", 32'(bus.mem_dout), 32'h5A);
    chk("rdy_hold_addr", bus.mem_a, 32'h310);
    nxt();
    chk("rdy_end_wr", 32'(bus.mem_wr), 32'd0);

    // LW flushed at cycle 3, SH accepted while flush is high
    bus.lsb_load_valid  = 1'b1;
    bus.lsb_load_type   = LOAD_LW;
    bus.lsb_load_addr   = 32'h100;
    bus.lsb_load_rob_id = 5'd9;
    nxt();
    bus.lsb_load_valid = 1'b0;
    nxt();
    nxt();
    bus.flush_in = 1'b1;
    nxt();
    #1;
    chk("fl_idle", 32'(bus.mem_busy), 32'd0);
    bus.rob_store_ready = 1'b1;
    bus.rob_store_type  = STORE_H;
    bus.rob_store_addr  = 32'h320;
    bus.rob_store_value = 32'h0000ABCD;
    nxt();
    bus.rob_store_ready = 1'b0;
    chk("fl_valid5", 32'(bus.mem_valid), 32'd0);
    nxt();
    chk("fl_valid6", 32'(bus.mem_valid), 32'd0);
    chk("fl_sh_wr0", 32'(bus.mem_wr), 32'd1);
    chk("fl_sh_a0", bus.mem_a, 32'h320);
    chk("fl_sh_d0", 32'(bus.mem_dout), 32'hCD);
    nxt();
    chk("fl_sh_wr1", 32'(bus.mem_wr), 32'd1);
    chk("fl_sh_a1", bus.mem_a, 32'h321);
    chk("fl_sh_d1", 32'(bus.mem_dout), 32'hAB);
    // load request during flush is not granted
    bus.lsb_load_valid  = 1'b1;
    bus.lsb_load_type   = LOAD_LB;
    bus.lsb_load_addr   = 32'h200;
    bus.lsb_load_rob_id = 5'd2;
    nxt();
    chk("fl_nogrant", 32'(bus.lsb_load_grant), 32'd0);
    chk("fl_sh_end", 32'(bus.mem_wr), 32'd0);
    bus.flush_in = 1'b0;
    nxt();
    chk("fl_grant", 32'(bus.lsb_load_grant), 32'd1);
    bus.lsb_load_valid = 1'b0;
    nxt();
    nxt();
    chk("fl_lb_valid", 32'(bus.mem_valid), 32'd1);
    chk("fl_lb_value", bus.mem_value, 32'hFFFFFF80);
    chk("fl_lb_dep", 32'(bus.mem_dependency), 32'd2);
    nxt();

    // Same-cycle store and load: store wins
    bus.rob_store_ready = 1'b1;
    bus.rob_store_type  = STORE_B;
    bus.rob_store_addr  = 32'h330;
    bus.rob_store_value = 32'h00000077;
    bus.lsb_load_valid  = 1'b1;
    bus.lsb_load_type   = LOAD_LBU;
    bus.lsb_load_addr   = 32'h200;
    bus.lsb_load_rob_id = 5'd6;
    nxt();
    bus.rob_store_ready = 1'b0;
    chk("arb_c1_grant", 32'(bus.lsb_load_grant), 32'd0);
    nxt();
    chk("arb_c2_grant", 32'(bus.lsb_load_grant), 32'd0);
    chk("arb_wr", 32'(bus.mem_wr), 32'd1);
    chk("arb_addr", bus.mem_a, 32'h330);
    chk("arb_dout", 32'(bus.mem_dout), 32'h77);
    nxt();
    chk("arb_grant", 32'(bus.lsb_load_grant), 32'd1);
    bus.lsb_load_valid = 1'b0;
    nxt();
    chk("arb_grant_pulse", 32'(bus.lsb_load_grant), 32'd0);
    nxt();
    chk("arb_valid", 32'(bus.mem_valid), 32'd1);
    chk("arb_value", bus.mem_value, 32'h00000080);
    chk("arb_dep", 32'(bus.mem_dependency), 32'd6);
    nxt();

    // Reset in the middle of a LW
    bus.lsb_load_valid  = 1'b1;
    bus.lsb_load_type   = LOAD_LW;
    bus.lsb_load_addr   = 32'h100;
    bus.lsb_load_rob_id = 5'd1;
    nxt();
    bus.lsb_load_valid = 1'b0;
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    chk("mrst_a", bus.mem_a, 32'h0);
    chk("mrst_dout", 32'(bus.mem_dout), 32'h0);
    chk("mrst_value", bus.mem_value, 32'h0);
    chk("mrst_dep", 32'(bus.mem_dependency), 32'd0);
    chk("mrst_busy", 32'(bus.mem_busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      nxt();
      chk("mrst_novalid", 32'(bus.mem_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
